// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAccess  = 2'd1,
    StRespond = 2'd2
  } arb_state_e;

  typedef enum logic {
    ReqInstr = 1'b0,
    ReqData  = 1'b1
  } req_id_e;

  localparam logic READ    = 1'b0;
  localparam logic WRITE   = 1'b1;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [3:0] FULL_MASK = 4'b1111;

endpackage

// File: rtl/memory_arbiter_timeout.sv
// Wait-cycle counter for a stalled memory access; expired flags the last allowed cycle.
module memory_arbiter_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] Last = CntW'(TIMEOUT_CYCLES - 1);
  localparam bit Enabled = (TIMEOUT_CYCLES != 0);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = Enabled && (cnt_q == Last);

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates the core's fetch and load/store ports onto one memory port,
// one registered transaction at a time, alternating on conflicts.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_read_data,
  output logic        instr_done,
  output logic        instr_error,
  input  logic        data_req,
  input  logic        data_state,
  input  logic [31:0] data_address,
  input  logic [3:0]  data_frame_mask,
  input  logic [31:0] data_write_data,
  output logic [31:0] data_read_data,
  output logic        data_done,
  output logic        data_error,
  output logic        mem_enable,
  output logic        mem_state,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_frame_mask,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready
);

  arb_state_e  state_q, state_d;
  req_id_e     grant_q, grant_d, last_grant_q, last_grant_d, pick;
  logic        mem_enable_q, mem_enable_d, mem_state_q, mem_state_d;
  logic [31:0] mem_address_q, mem_address_d, mem_write_data_q, mem_write_data_d;
  logic [3:0]  mem_frame_mask_q, mem_frame_mask_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] instr_read_data_q, instr_read_data_d, data_read_data_q, data_read_data_d;
  logic        instr_done_q, instr_done_d, instr_error_q, instr_error_d;
  logic        data_done_q, data_done_d, data_error_q, data_error_d;
  logic        tmo_clear, tmo_enable, tmo_expired;

  memory_arbiter_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    last_grant_d      = last_grant_q;
    mem_enable_d      = mem_enable_q;
    mem_state_d       = mem_state_q;
    mem_address_d     = mem_address_q;
    mem_frame_mask_d  = mem_frame_mask_q;
    mem_write_data_d  = mem_write_data_q;
    rsp_data_d        = rsp_data_q;
    rsp_err_d         = rsp_err_q;
    instr_read_data_d = instr_read_data_q;
    data_read_data_d  = data_read_data_q;
    instr_done_d      = 1'b0;
    instr_error_d     = 1'b0;
    data_done_d       = 1'b0;
    data_error_d      = 1'b0;
    tmo_clear         = 1'b0;
    tmo_enable        = 1'b0;
    pick              = ReqInstr;

    unique case (state_q)
      StIdle: begin
        if (instr_req || data_req) begin
          // On conflict, serve whoever did not win last time.
          if (instr_req && data_req) begin
            pick = (last_grant_q == ReqInstr) ? ReqData : ReqInstr;
          end else begin
            pick = data_req ? ReqData : ReqInstr;
          end
          grant_d      = pick;
          last_grant_d = pick;
          mem_enable_d = ENABLE;
          if (pick == ReqData) begin
            mem_state_d      = data_state;
            mem_address_d    = data_address;
            mem_frame_mask_d = data_frame_mask;
            mem_write_data_d = data_write_data;
          end else begin
            mem_state_d      = READ;
            mem_address_d    = instr_address;
            mem_frame_mask_d = FULL_MASK;
            mem_write_data_d = '0;
          end
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (mem_ready) begin
          rsp_data_d   = (mem_state_q == WRITE) ? '0 : mem_read_data;
          rsp_err_d    = 1'b0;
          mem_enable_d = DISABLE;
          tmo_clear    = 1'b1;
          state_d      = StRespond;
        end else if (tmo_expired) begin
          rsp_data_d   = '0;
          rsp_err_d    = 1'b1;
          mem_enable_d = DISABLE;
          tmo_clear    = 1'b1;
          state_d      = StRespond;
        end else begin
          tmo_enable = 1'b1;
        end
      end
      StRespond: begin
        if (grant_q == ReqData) begin
          data_done_d      = 1'b1;
          data_error_d     = rsp_err_q;
          data_read_data_d = rsp_data_q;
        end else begin
          instr_done_d      = 1'b1;
          instr_error_d     = rsp_err_q;
          instr_read_data_d = rsp_data_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= StIdle;
      grant_q           <= ReqInstr;
      last_grant_q      <= ReqInstr;
      mem_enable_q      <= DISABLE;
      mem_state_q       <= READ;
      mem_address_q     <= '0;
      mem_frame_mask_q  <= '0;
      mem_write_data_q  <= '0;
      rsp_data_q        <= '0;
      rsp_err_q         <= 1'b0;
      instr_read_data_q <= '0;
      data_read_data_q  <= '0;
      instr_done_q      <= 1'b0;
      instr_error_q     <= 1'b0;
      data_done_q       <= 1'b0;
      data_error_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      grant_q           <= grant_d;
      last_grant_q      <= last_grant_d;
      mem_enable_q      <= mem_enable_d;
      mem_state_q       <= mem_state_d;
      mem_address_q     <= mem_address_d;
      mem_frame_mask_q  <= mem_frame_mask_d;
      mem_write_data_q  <= mem_write_data_d;
      rsp_data_q        <= rsp_data_d;
      rsp_err_q         <= rsp_err_d;
      instr_read_data_q <= instr_read_data_d;
      data_read_data_q  <= data_read_data_d;
      instr_done_q      <= instr_done_d;
      instr_error_q     <= instr_error_d;
      data_done_q       <= data_done_d;
      data_error_q      <= data_error_d;
    end
  end

  assign mem_enable      = mem_enable_q;
  assign mem_state       = mem_state_q;
  assign mem_address     = mem_address_q;
  assign mem_frame_mask  = mem_frame_mask_q;
  assign mem_write_data  = mem_write_data_q;
  assign instr_read_data = instr_read_data_q;
  assign instr_done      = instr_done_q;
  assign instr_error     = instr_error_q;
  assign data_read_data  = data_read_data_q;
  assign data_done       = data_done_q;
  assign data_error      = data_error_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a default-timeout instance for the main flows and a
// TIMEOUT_CYCLES=4 instance for the stalled-access path.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req, data_req, t_instr_req, t_data_req;
  logic [31:0] instr_address, data_address, data_write_data, mem_read_data;
  logic        data_state, mem_ready;
  logic [3:0]  data_frame_mask;

  logic [31:0] instr_read_data, data_read_data, mem_address, mem_write_data;
  logic        instr_done, instr_error, data_done, data_error, mem_enable, mem_state;
  logic [3:0]  mem_frame_mask;

  logic [31:0] t_instr_read_data, t_data_read_data, t_mem_address, t_mem_write_data;
  logic        t_instr_done, t_instr_error, t_data_done, t_data_error, t_mem_enable, t_mem_state;
  logic [3:0]  t_mem_frame_mask;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_instr_rd = '0;
  logic [31:0] last_data_rd = '0;

  always #5 clk = ~clk;

  memory_arbiter dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_address(instr_address),
    .instr_read_data(instr_read_data), .instr_done(instr_done), .instr_error(instr_error),
    .data_req(data_req), .data_state(data_state), .data_address(data_address),
    .data_frame_mask(data_frame_mask), .data_write_data(data_write_data),
    .data_read_data(data_read_data), .data_done(data_done), .data_error(data_error),
    .mem_enable(mem_enable), .mem_state(mem_state), .mem_address(mem_address),
    .mem_frame_mask(mem_frame_mask), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready)
  );

  memory_arbiter #(.TIMEOUT_CYCLES(4)) dut_t4 (
    .clk(clk), .reset(reset),
    .instr_req(t_instr_req), .instr_address(instr_address),
    .instr_read_data(t_instr_read_data), .instr_done(t_instr_done),
    .instr_error(t_instr_error),
    .data_req(t_data_req), .data_state(data_state), .data_address(data_address),
    .data_frame_mask(data_frame_mask), .data_write_data(data_write_data),
    .data_read_data(t_data_read_data), .data_done(t_data_done), .data_error(t_data_error),
    .mem_enable(t_mem_enable), .mem_state(t_mem_state), .mem_address(t_mem_address),
    .mem_frame_mask(t_mem_frame_mask), .mem_write_data(t_mem_write_data),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_data, input logic [31:0] rd, input logic err);
    exp_t e;
    e.is_data = is_data;
    e.rdata   = rd;
    e.err     = err;
    sb.push_back(e);
  endtask

  // Called #1 after the grant edge; plays the memory with the given wait states.
  task automatic mem_serve(input logic [31:0] rdata, input int waits, input logic [31:0] ea,
                           input logic [3:0] em, input logic es, input logic chk_wd,
                           input logic [31:0] ewd);
    chk("grant_done_low", {30'b0, instr_done, data_done}, 32'h0);
    for (int i = 0; i <= waits; i++) begin
      chk("mem_enable", mem_enable, 32'h1);
      chk("mem_address", mem_address, ea);
      chk("mem_frame_mask", mem_frame_mask, em);
      chk("mem_state", mem_state, es);
      if (chk_wd) chk("mem_write_data", mem_write_data, ewd);
      if (i < waits) begin
        mem_ready = 1'b0;
        tick;
        chk("no_done_in_wait", {30'b0, instr_done, data_done}, 32'h0);
      end
    end
    mem_ready     = 1'b1;
    mem_read_data = rdata;
    tick;
    mem_ready     = 1'b0;
    mem_read_data = $urandom;
    chk("mem_enable_respond", mem_enable, 32'h0);
  endtask

  task automatic expect_done;
    exp_t e;
    tick;
    n_checks++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("instr_done", instr_done, {31'b0, !e.is_data});
      chk("data_done", data_done, {31'b0, e.is_data});
      if (e.is_data) begin
        chk("data_read_data", data_read_data, e.rdata);
        chk("data_error", data_error, {31'b0, e.err});
        chk("instr_rd_held", instr_read_data, last_instr_rd);
        last_data_rd = e.rdata;
      end else begin
        chk("instr_read_data", instr_read_data, e.rdata);
        chk("instr_error", instr_error, {31'b0, e.err});
        chk("data_rd_held", data_read_data, last_data_rd);
        last_instr_rd = e.rdata;
      end
    end
  endtask

  task automatic conflict(input logic [31:0] drd, input logic [31:0] ird);
    instr_req = 1'b1; instr_address = 32'h4;
    data_req = 1'b1; data_state = READ; data_address = 32'h100;
    data_frame_mask = 4'b1111; data_write_data = 32'h0;
    push(1'b1, drd, 1'b0);
    push(1'b0, ird, 1'b0);
    tick;
    mem_serve(drd, 0, 32'h100, 4'b1111, READ, 1'b0, 32'h0);
    expect_done;
    data_req = 1'b0;
    tick;
    mem_serve(ird, 0, 32'h4, 4'b1111, READ, 1'b0, 32'h0);
    expect_done;
    instr_req = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rd;
    logic [3:0]  rm;
    reset = 1'b0;
    instr_req = 1'b0; data_req = 1'b0; t_instr_req = 1'b0; t_data_req = 1'b0;
    instr_address = '0; data_address = '0; data_write_data = '0; data_state = READ;
    data_frame_mask = '0; mem_read_data = '0; mem_ready = 1'b0;
    #12;
    chk("rst_mem_enable", mem_enable, 32'h0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_frame_mask", mem_frame_mask, 32'h0);
    chk("rst_done", {28'b0, instr_done, data_done, instr_error, data_error}, 32'h0);
    chk("rst_instr_rd", instr_read_data, 32'h0);
    chk("rst_data_rd", data_read_data, 32'h0);
    reset = 1'b1;
    tick;

    // First conflict after reset goes to data, then alternation holds.
    conflict(32'hAAAA_0001, 32'hBBBB_0002);
    conflict(32'hAAAA_0003, 32'hBBBB_0004);

    // Single fetch, zero wait.
    instr_req = 1'b1; instr_address = 32'h10;
    push(1'b0, 32'h0050_0093, 1'b0);
    tick;
    mem_serve(32'h0050_0093, 0, 32'h10, 4'b1111, READ, 1'b0, 32'h0);
    expect_done;
    instr_req = 1'b0;

    // Data write returns zero read data.
    data_req = 1'b1; data_state = WRITE; data_address = 32'h1000_0000;
    data_frame_mask = 4'b0001; data_write_data = 32'h41;
    push(1'b1, 32'h0, 1'b0);
    tick;
    mem_serve(32'hDEAD_BEEF, 1, 32'h1000_0000, 4'b0001, WRITE, 1'b1, 32'h41);
    expect_done;
    data_req = 1'b0;

    // Timeout on the TIMEOUT_CYCLES=4 instance.
    t_data_req = 1'b1; data_state = READ; data_address = 32'h200; data_frame_mask = 4'b1111;
    mem_ready = 1'b0;
    tick;
    chk("t4_mem_enable", t_mem_enable, 32'h1);
    chk("t4_mem_address", t_mem_address, 32'h200);
    for (int i = 1; i <= 4; i++) begin
      tick;
      chk("t4_no_done_early", t_data_done, 32'h0);
    end
    tick;
    chk("t4_timeout_done", t_data_done, 32'h1);
    chk("t4_timeout_error", t_data_error, 32'h1);
    chk("t4_timeout_rd", t_data_read_data, 32'h0);
    chk("t4_instr_quiet", {30'b0, t_instr_done, t_instr_error}, 32'h0);
    t_data_req = 1'b0;
    tick;
    t_data_req = 1'b1;
    tick;
    mem_ready = 1'b1; mem_read_data = 32'h1234_5678;
    tick;
    mem_ready = 1'b0;
    chk("t4_enable_off", t_mem_enable, 32'h0);
    tick;
    chk("t4_after_done", t_data_done, 32'h1);
    chk("t4_after_error", t_data_error, 32'h0);
    chk("t4_after_rd", t_data_read_data, 32'h1234_5678);
    t_data_req = 1'b0;
    tick;

    // Reset while ACCESS is waiting: transaction abandoned, no done.
    data_req = 1'b1; data_state = READ; data_address = 32'h300; data_frame_mask = 4'b1111;
    tick;
    chk("pre_reset_enable", mem_enable, 32'h1);
    mem_ready = 1'b0;
    tick;
    tick;
    #3 reset = 1'b0;
    #1;
    chk("async_reset_enable", mem_enable, 32'h0);
    data_req = 1'b0;
    tick;
    chk("reset_no_done", {30'b0, instr_done, data_done}, 32'h0);
    reset = 1'b1;
    last_instr_rd = '0;
    last_data_rd  = '0;
    tick;
    chk("post_reset_no_done", {30'b0, instr_done, data_done}, 32'h0);
    instr_req = 1'b1; instr_address = 32'h20;
    push(1'b0, 32'h0000_0013, 1'b0);
    tick;
    mem_serve(32'h0000_0013, 0, 32'h20, 4'b1111, READ, 1'b0, 32'h0);
    expect_done;
    instr_req = 1'b0;
    conflict(32'hCCCC_0005, 32'hDDDD_0006);

    // Wait-state sweep with random masks.
    for (int w = 0; w < 8; w++) begin
      ra = $urandom & 32'hFFFF_FFFC;
      rd = $urandom;
      rm = 4'($urandom_range(15));
      data_req = 1'b1; data_state = READ; data_address = ra;
      data_frame_mask = rm; data_write_data = 32'h5A00_0000 | 32'(w);
      push(1'b1, rd, 1'b0);
      tick;
      mem_serve(rd, w, ra, rm, READ, 1'b1, 32'h5A00_0000 | 32'(w));
      expect_done;
      data_req = 1'b0;
    end
    tick;
    chk("sb_drained", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
